// File: rtl/lfsr_sched_if.sv
// Request, seed and random-word stream bundle for lfsr_sched.
// The master drives requests and readiness; the slave returns words.
interface lfsr_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic             seed_we;
  logic [7:0]       seed;
  logic             rnd_ready;
  logic [N_REQ-1:0] grant;
  logic             rnd_valid;
  logic [7:0]       rnd_data;
  logic             busy;

  modport master (
    output req,
    output seed_we,
    output seed,
    output rnd_ready,
    input  grant,
    input  rnd_valid,
    input  rnd_data,
    input  busy
  );

  modport slave (
    input  req,
    input  seed_we,
    input  seed,
    input  rnd_ready,
    output grant,
    output rnd_valid,
    output rnd_data,
    output busy
  );
endinterface

// File: rtl/lfsr_sched.sv
// Round-robin sharing of one 8-bit Fibonacci LFSR among N_REQ clients.
// Each grant streams BURST words; aborts and seed loads keep the state nonzero.
module lfsr_sched #(
  parameter int N_REQ = 4,
  parameter int BURST = 4
) (
  input logic         clk,
  input logic         rst_n,
  lfsr_sched_if.slave bus
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] grant_d;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    last_d;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    gidx_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  logic             hs;
  logic             last_word;
  logic             done;
  logic             abort;
  logic             fb;
  logic [7:0]       lfsr_adv;
  logic             win_vld;
  logic [IW-1:0]    win_idx;

  assign hs        = (state_q == S_BURST) & bus.rnd_ready;
  assign last_word = (cnt_q == CW'(BURST - 1));
  assign done      = hs & last_word;
  assign abort     = ~hs & ~bus.req[gidx_q];

  // s1 is bit 7, so taps s8,s6,s5,s4 sit at bits 0,2,3,4
  assign fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4];
  assign lfsr_adv = {fb, lfsr_q[7:1]};

  always_comb begin
    int            j;
    logic [IW-1:0] jx;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    jx      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = int'(last_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jx = IW'(j);
      if (!win_vld && bus.req[jx]) begin
        win_vld = 1'b1;
        win_idx = jx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.seed_we && win_vld) state_d = S_BURST;
      end
      S_BURST: begin
        if (done || abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rnd_valid = (state_q == S_BURST);
    bus.busy      = (state_q == S_BURST);
    bus.grant     = grant_q;
    bus.rnd_data  = lfsr_q;
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    grant_d = grant_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.seed_we) begin
          lfsr_d = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        end else if (win_vld) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          gidx_d  = win_idx;
          cnt_d   = '0;
        end
      end
      S_BURST: begin
        if (hs) begin
          lfsr_d = lfsr_adv;
          cnt_d  = cnt_q + 1'b1;
        end
        if (done || abort) begin
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= 8'h01;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      gidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
